// File: rtl/xc20xx_cfg_pkg.sv
// Shared definitions for the XC20XX serial configuration loader:
// FSM state encoding, bitstream framing constants and the expected
// length-count helper.
package xc20xx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_LEN   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_FIN   = 3'd5,
    ST_FAIL  = 3'd6
  } cfg_state_e;

  localparam logic [7:0] PREAMBLE  = 8'hF2;
  localparam int         LEN_W     = 24;
  localparam int         STOP_BITS = 3;

  // Each frame carries one start bit, the data bits and the stop bits.
  function automatic logic [LEN_W-1:0] exp_len(input int frame_bits, input int num_frames);
    return LEN_W'(num_frames * (frame_bits + STOP_BITS + 1));
  endfunction

endpackage

// File: rtl/xc20xx_cfg_shreg.sv
// CE-gated MSB-first shift register with synchronous clear. New bits enter
// at bit 0, so the first bit shifted in ends up in bit W-1 after W shifts.
module xc20xx_cfg_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         ce,
  input  logic         din,
  output logic [W-1:0] q
);

  // Shift on enabled cycles, clear on reset, otherwise hold.
  always_ff @(posedge clk) begin
    if (srst) begin
      q <= {W{1'b0}};
    end else if (ce) begin
      q <= {q[W-2:0], din};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration loader: hunts for the preamble, checks the length
// count, then deframes start/data/stop fields into parallel frame writes.
module xc20xx_cfg_loader
  import xc20xx_cfg_pkg::*;
#(
  parameter int FRAME_BITS = 46,
  parameter int NUM_FRAMES = 160,
  parameter int ADDR_W     = 8
) (
  input  logic                  CCLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  DIN,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [ADDR_W-1:0]     FRAME_ADDR,
  output logic                  FRAME_WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int               CNT_MAX = (FRAME_BITS > LEN_W) ? FRAME_BITS : LEN_W;
  localparam int               CNT_W   = $clog2(CNT_MAX);
  localparam logic [LEN_W-1:0] EXP_LEN = exp_len(FRAME_BITS, NUM_FRAMES);

  cfg_state_e              state_r, state_s;
  logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_s;
  logic [ADDR_W-1:0]       frame_cnt_r, frame_cnt_s;
  logic                    we_s;
  logic                    hist_ce_s, frame_ce_s;
  logic [LEN_W-1:0]        hist_q_s;
  logic [FRAME_BITS-1:0]   frame_q_s;
  logic                    unused_hist_msb_s;

  // The history register only moves while hunting or reading the length;
  // the frame register only while data bits arrive.
  assign hist_ce_s  = CE & ((state_r == ST_HUNT) | (state_r == ST_LEN));
  assign frame_ce_s = CE & (state_r == ST_DATA);
  // The oldest history bit is shifted out on the final length bit.
  assign unused_hist_msb_s = hist_q_s[LEN_W-1];

  xc20xx_cfg_shreg #(.W(LEN_W)) u_hist (
    .clk  (CCLK),
    .srst (RESET),
    .ce   (hist_ce_s),
    .din  (DIN),
    .q    (hist_q_s)
  );

  xc20xx_cfg_shreg #(.W(FRAME_BITS)) u_frame (
    .clk  (CCLK),
    .srst (RESET),
    .ce   (frame_ce_s),
    .din  (DIN),
    .q    (frame_q_s)
  );

  // Next-state, counter and write-strobe decode; nothing moves without CE.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    frame_cnt_s = frame_cnt_r;
    we_s        = 1'b0;
    if (CE) begin
      case (state_r)
        ST_HUNT: begin
          if ({hist_q_s[6:0], DIN} == PREAMBLE) begin
            state_s   = ST_LEN;
            bit_cnt_s = CNT_W'(0);
          end else begin
            state_s   = ST_HUNT;
          end
        end
        ST_LEN: begin
          if (bit_cnt_r == CNT_W'(LEN_W - 1)) begin
            bit_cnt_s = CNT_W'(0);
            if ({hist_q_s[LEN_W-2:0], DIN} == EXP_LEN) begin
              state_s = ST_START;
            end else begin
              state_s = ST_FAIL;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
        ST_START: begin
          bit_cnt_s = CNT_W'(0);
          if (!DIN) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_FAIL;
          end
        end
        ST_DATA: begin
          if (bit_cnt_r == CNT_W'(FRAME_BITS - 1)) begin
            state_s   = ST_STOP;
            bit_cnt_s = CNT_W'(0);
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (!DIN) begin
            state_s = ST_FAIL;
          end else if (bit_cnt_r == CNT_W'(STOP_BITS - 1)) begin
            we_s        = 1'b1;
            bit_cnt_s   = CNT_W'(0);
            frame_cnt_s = frame_cnt_r + ADDR_W'(1);
            if (frame_cnt_r == ADDR_W'(NUM_FRAMES - 1)) begin
              state_s = ST_FIN;
            end else begin
              state_s = ST_START;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
        ST_FIN:  state_s = ST_FIN;
        ST_FAIL: state_s = ST_FAIL;
        default: state_s = ST_FAIL;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and registered outputs; status flags follow the next state
  // so BUSY/DONE/ERR change on the same edge as the transition.
  always_ff @(posedge CCLK) begin
    if (RESET) begin
      state_r     <= ST_HUNT;
      bit_cnt_r   <= CNT_W'(0);
      frame_cnt_r <= ADDR_W'(0);
      FRAME_DATA  <= {FRAME_BITS{1'b0}};
      FRAME_ADDR  <= ADDR_W'(0);
      FRAME_WE    <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      frame_cnt_r <= frame_cnt_s;
      FRAME_WE    <= we_s;
      FRAME_DATA  <= we_s ? frame_q_s : FRAME_DATA;
      FRAME_ADDR  <= we_s ? frame_cnt_r : FRAME_ADDR;
      BUSY        <= (state_s == ST_LEN) | (state_s == ST_START) |
                     (state_s == ST_DATA) | (state_s == ST_STOP);
      DONE        <= (state_s == ST_FIN);
      ERR         <= (state_s == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Self-checking bench for xc20xx_cfg_loader: builds bitstreams, predicts the
// frame writes and final status with a stream-level parser, and compares.
module tb_xc20xx_cfg_loader;

  localparam int FB = 46;
  localparam int NF = 160;
  localparam int AW = 8;

  logic          CCLK = 1'b0;
  logic          RESET, CE, DIN;
  logic [FB-1:0] FRAME_DATA;
  logic [AW-1:0] FRAME_ADDR;
  logic          FRAME_WE, BUSY, DONE, ERR;

  int            n_assert = 0;
  int            n_fail   = 0;
  bit            stream[$];
  int            exp_addr[$];
  logic [FB-1:0] exp_data[$];
  int            got_addr[$];
  logic [FB-1:0] got_data[$];
  bit            exp_done, exp_err, err_seen;
  logic          prev_we;

  xc20xx_cfg_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .ADDR_W(AW)) dut (
    .CCLK(CCLK), .RESET(RESET), .CE(CE), .DIN(DIN),
    .FRAME_DATA(FRAME_DATA), .FRAME_ADDR(FRAME_ADDR), .FRAME_WE(FRAME_WE),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CCLK = ~CCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference parser: reads the stream with the format rules and lists the
  // writes that must occur plus the final DONE/ERR status.
  function automatic void model();
    int            i = 0;
    logic [7:0]    h = 8'h00;
    logic [23:0]   len = 24'h0;
    logic [FB-1:0] d;
    bit            locked = 1'b0;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    while (i < stream.size() && !locked) begin
      h = {h[6:0], stream[i]};
      i++;
      locked = (h == 8'hF2);
    end
    if (!locked || i + 24 > stream.size()) return;
    for (int k = 0; k < 24; k++) begin len = {len[22:0], stream[i]}; i++; end
    if (len != 24'(NF * (FB + 4))) begin exp_err = 1'b1; return; end
    for (int f = 0; f < NF; f++) begin
      if (i + FB + 4 > stream.size()) return;
      if (stream[i] != 1'b0) begin exp_err = 1'b1; return; end
      i++;
      d = '0;
      for (int k = 0; k < FB; k++) begin d = {d[FB-2:0], stream[i]}; i++; end
      for (int s = 0; s < 3; s++) begin
        if (stream[i] != 1'b1) begin exp_err = 1'b1; return; end
        i++;
      end
      exp_addr.push_back(f);
      exp_data.push_back(d);
    end
    exp_done = 1'b1;
  endfunction

  task automatic push(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stream.push_back(v[k]);
  endtask

  // Full stream; rnd selects random frame data, bad_frame gets stop field 110.
  task automatic build(input bit rnd, input int bad_frame, input logic [23:0] len);
    logic [FB-1:0] d;
    logic [7:0]    idx;
    stream.delete();
    push(64'(12'hFF2), 12);
    push(64'(len), 24);
    for (int f = 0; f < NF; f++) begin
      idx = 8'(f);
      d = rnd ? FB'({$urandom(), $urandom()}) : FB'({6{idx}});
      push(64'd0, 1);
      push(64'(d), FB);
      push((f == bad_frame) ? 64'(3'b110) : 64'(3'b111), 3);
    end
  endtask

  // Drive stream[from..to-1]; with rnd, random CE=0 gaps carry junk on DIN.
  task automatic send(input int from, input int to, input bit rnd);
    for (int k = from; k < to; k++) begin
      int tries = 0;
      if (rnd) begin
        while ($urandom_range(1, 0) == 0 && tries < 20) begin
          CE = 1'b0; DIN = 1'($urandom_range(1, 0));
          @(posedge CCLK); #1;
          tries++;
        end
      end
      CE = 1'b1; DIN = stream[k];
      @(posedge CCLK); #1;
    end
    CE = 1'b0;
  endtask

  task automatic idle(input int n);
    CE = 1'b0;
    repeat (n) begin @(posedge CCLK); #1; end
  endtask

  // Reset with CE=1 and DIN=1 so reset has to win over a live bit.
  task automatic do_reset();
    RESET = 1'b1; CE = 1'b1; DIN = 1'b1;
    @(posedge CCLK); #1;
    RESET = 1'b0; CE = 1'b0;
    got_addr.delete(); got_data.delete();
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_data"}, 64'(FRAME_DATA), 64'd0);
    check({name, "_addr"}, 64'(FRAME_ADDR), 64'd0);
    check({name, "_we"},   64'(FRAME_WE),   64'd0);
    check({name, "_busy"}, 64'(BUSY),       64'd0);
    check({name, "_done"}, 64'(DONE),       64'd0);
    check({name, "_err"},  64'(ERR),        64'd0);
  endtask

  task automatic compare_writes(input string name);
    check({name, "_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
      check($sformatf("%s_addr[%0d]", name, k), 64'(got_addr[k]), 64'(exp_addr[k]));
      check($sformatf("%s_data[%0d]", name, k), 64'(got_data[k]), 64'(exp_data[k]));
    end
  endtask

  // Write collector and strobe-width monitor, sampled on the falling edge.
  initial begin
    prev_we = 1'b0;
    forever begin
      @(negedge CCLK);
      if (FRAME_WE === 1'b1) begin
        check("we_width", 64'(prev_we), 64'd0);
        got_addr.push_back(int'(FRAME_ADDR));
        got_data.push_back(FRAME_DATA);
      end
      if (ERR === 1'b1) err_seen = 1'b1;
      prev_we = FRAME_WE;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] nz;
    int          n;
    RESET = 1'b1; CE = 1'b0; DIN = 1'b0;
    repeat (2) @(posedge CCLK);
    #1;
    RESET = 1'b0;
    check_reset_state("rst");

    // Noise, then the nominal stream with CE held high.
    build(1'b0, -1, 24'h001F40);
    nz = 16'b1110_0010_0101_0101;
    for (int k = 0; k < 16; k++) stream.push_front(nz[k]);
    model();
    n = stream.size();
    err_seen = 1'b0;
    send(0, 16, 1'b0);
    check("noise_busy", 64'(BUSY), 64'd0);
    send(16, 27, 1'b0);
    check("pre_busy", 64'(BUSY), 64'd0);
    send(27, 28, 1'b0);
    check("lock_busy", 64'(BUSY), 64'd1);
    send(28, n - 1, 1'b0);
    check("nom_done_early", 64'(DONE), 64'd0);
    send(n - 1, n, 1'b0);
    check("nom_done_edge", 64'(DONE), 64'd1);
    check("nom_we_edge", 64'(FRAME_WE), 64'd1);
    check("nom_busy_end", 64'(BUSY), 64'd0);
    idle(3);
    check("nom_we_after", 64'(FRAME_WE), 64'd0);
    check("nom_data_hold", 64'(FRAME_DATA), 64'(exp_data[NF-1]));
    compare_writes("nom");
    check("nom_done", 64'(DONE), 64'(exp_done));
    check("nom_err", 64'(ERR), 64'(exp_err));
    check("nom_err_seen", 64'(err_seen), 64'd0);

    // Random data with random CE gaps.
    do_reset();
    build(1'b1, -1, 24'h001F40);
    model();
    send(0, stream.size(), 1'b1);
    idle(3);
    compare_writes("ce");
    check("ce_done", 64'(DONE), 64'(exp_done));
    check("ce_err", 64'(ERR), 64'(exp_err));

    // Wrong length count.
    do_reset();
    build(1'b0, -1, 24'h001F3F);
    model();
    send(0, 35, 1'b0);
    check("len_err_early", 64'(ERR), 64'd0);
    check("len_busy_early", 64'(BUSY), 64'd1);
    send(35, 36, 1'b0);
    check("len_err_edge", 64'(ERR), 64'd1);
    check("len_busy_edge", 64'(BUSY), 64'd0);
    send(36, 200, 1'b1);
    idle(3);
    compare_writes("len");
    check("len_err", 64'(ERR), 64'(exp_err));
    check("len_done", 64'(DONE), 64'(exp_done));

    // Frame 5 with a bad third stop bit, followed by ignored traffic.
    do_reset();
    build(1'b1, 5, 24'h001F40);
    model();
    send(0, 335, 1'b1);
    check("stop_err_early", 64'(ERR), 64'd0);
    send(335, 336, 1'b1);
    check("stop_err_edge", 64'(ERR), 64'd1);
    send(336, 736, 1'b1);
    idle(3);
    compare_writes("stop");
    check("stop_err", 64'(ERR), 64'(exp_err));
    check("stop_done", 64'(DONE), 64'd0);
    check("stop_busy", 64'(BUSY), 64'd0);

    // Reset in the middle of frame 20, then a complete stream.
    do_reset();
    build(1'b1, -1, 24'h001F40);
    send(0, 36 + 20 * 50 + 20, 1'b0);
    idle(2);
    check("mid_count", 64'(got_addr.size()), 64'd20);
    do_reset();
    check_reset_state("mid_rst");
    build(1'b0, -1, 24'h001F40);
    model();
    send(0, stream.size(), 1'b0);
    idle(3);
    compare_writes("restart");
    check("restart_done", 64'(DONE), 64'(exp_done));
    check("restart_err", 64'(ERR), 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
